// File: rtl/date_pkg.sv
// Shared widths and calendar constants for the date counter slice.
package date_pkg;
   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;
   localparam int unsigned YEAR_W  = 7;

   localparam logic [YEAR_W-1:0]  MAX_YEAR  = 7'd99;
   localparam logic [MONTH_W-1:0] MONTH_FEB = 4'd2;
   localparam logic [MONTH_W-1:0] MONTH_DEC = 4'd12;
endpackage

// File: rtl/month_length.sv
// Days-in-month decode; months outside 1..12 decode to 0 so they never validate.
module month_length
   import date_pkg::*;
(
   input  logic [MONTH_W-1:0] month,
   input  logic               leap,
   output logic [DAY_W-1:0]   dim
);
   always_comb begin
      dim = '0;
      case (month)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: dim = 5'd31;
         4'd4, 4'd6, 4'd9, 4'd11:                    dim = 5'd30;
         MONTH_FEB:                                  dim = leap ? 5'd29 : 5'd28;
         default:                                    dim = '0;
      endcase
   end
endmodule

// File: rtl/date_counter.sv
// Calendar date counter (2000..2099) with tick advance and validated load.
// Define DATE_COUNTER_LEAP_YEAR_EN to give February 29 days when year[1:0]==0.
module date_counter
   import date_pkg::*;
#(
   parameter int unsigned START_YEAR = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               load,
   input  logic [DAY_W-1:0]   load_day,
   input  logic [MONTH_W-1:0] load_month,
   input  logic [YEAR_W-1:0]  load_year,
   output logic [DAY_W-1:0]   day,
   output logic [MONTH_W-1:0] month,
   output logic [YEAR_W-1:0]  year,
   output logic [DAY_W-1:0]   dim,
   output logic               month_end,
   output logic               year_wrap,
   output logic               load_err
);
   logic             cur_leap;
   logic             load_leap;
   logic [DAY_W-1:0] load_dim;
   logic             load_ok;

`ifdef DATE_COUNTER_LEAP_YEAR_EN
   assign cur_leap  = (year[1:0] == 2'b00);
   assign load_leap = (load_year[1:0] == 2'b00);
`else
   assign cur_leap  = 1'b0;
   assign load_leap = 1'b0;
`endif

   month_length u_cur_len (
      .month (month),
      .leap  (cur_leap),
      .dim   (dim)
   );

   month_length u_load_len (
      .month (load_month),
      .leap  (load_leap),
      .dim   (load_dim)
   );

   // load_dim is 0 for an out-of-range month, so the day test also rejects it
   assign load_ok = (load_year <= MAX_YEAR) && (load_day != '0) && (load_day <= load_dim);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         day       <= DAY_W'(1);
         month     <= MONTH_W'(1);
         year      <= YEAR_W'(START_YEAR);
         month_end <= 1'b0;
         year_wrap <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         month_end <= 1'b0;
         year_wrap <= 1'b0;
         load_err  <= 1'b0;
         if (load) begin
            if (load_ok) begin
               day   <= load_day;
               month <= load_month;
               year  <= load_year;
            end else begin
               load_err <= 1'b1;
            end
         end else if (tick) begin
            if (day < dim) begin
               day <= day + DAY_W'(1);
            end else begin
               day       <= DAY_W'(1);
               month_end <= 1'b1;
               if (month == MONTH_DEC) begin
                  month     <= MONTH_W'(1);
                  year_wrap <= 1'b1;
                  year      <= (year == MAX_YEAR) ? '0 : year + YEAR_W'(1);
               end else begin
                  month <= month + MONTH_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_date_counter.sv
// Directed scoreboard bench for date_counter; follows DATE_COUNTER_LEAP_YEAR_EN.
module tb_date_counter;
   localparam int unsigned SY = 7;

   logic       clk = 1'b0;
   logic       rst_n, tick, load;
   logic [4:0] load_day, day, dim;
   logic [3:0] load_month, month;
   logic [6:0] load_year, year;
   logic       month_end, year_wrap, load_err;

   typedef struct {
      string      tag;
      logic [4:0] d;
      logic [3:0] m;
      logic [6:0] y;
      logic       me;
      logic       yw;
      logic       le;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   date_counter #(.START_YEAR(SY)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .load       (load),
      .load_day   (load_day),
      .load_month (load_month),
      .load_year  (load_year),
      .day        (day),
      .month      (month),
      .year       (year),
      .dim        (dim),
      .month_end  (month_end),
      .year_wrap  (year_wrap),
      .load_err   (load_err)
   );

   function automatic logic [4:0] exp_dim(input logic [3:0] m, input logic [6:0] y);
      logic [4:0] tbl [1:12];
      tbl = '{5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31};
`ifdef DATE_COUNTER_LEAP_YEAR_EN
      if (m == 4'd2 && (y % 4) == 0) return 5'd29;
`endif
      return tbl[m];
   endfunction

   task automatic compare();
      exp_t e;
      logic [4:0] ed;
      e  = q.pop_front();
      ed = exp_dim(e.m, e.y);
      checks++; assert (day === e.d) else begin failures++; $error("FAIL %s day got=%0d exp=%0d", e.tag, day, e.d); end
      checks++; assert (month === e.m) else begin failures++; $error("FAIL %s month got=%0d exp=%0d", e.tag, month, e.m); end
      checks++; assert (year === e.y) else begin failures++; $error("FAIL %s year got=%0d exp=%0d", e.tag, year, e.y); end
      checks++; assert (dim === ed) else begin failures++; $error("FAIL %s dim got=%0d exp=%0d", e.tag, dim, ed); end
      checks++; assert (month_end === e.me) else begin failures++; $error("FAIL %s month_end got=%b exp=%b", e.tag, month_end, e.me); end
      checks++; assert (year_wrap === e.yw) else begin failures++; $error("FAIL %s year_wrap got=%b exp=%b", e.tag, year_wrap, e.yw); end
      checks++; assert (load_err === e.le) else begin failures++; $error("FAIL %s load_err got=%b exp=%b", e.tag, load_err, e.le); end
   endtask

   // drive one cycle of stimulus, queue its expected result, check after the edge
   task automatic step(input string tag, input logic r, input logic t, input logic l,
                       input int ld, input int lm, input int ly,
                       input int ed, input int em, input int ey,
                       input logic eme, input logic eyw, input logic ele);
      exp_t e;
      @(negedge clk);
      rst_n      = r;
      tick       = t;
      load       = l;
      load_day   = 5'(ld);
      load_month = 4'(lm);
      load_year  = 7'(ly);
      e = '{tag, 5'(ed), 4'(em), 7'(ey), eme, eyw, ele};
      q.push_back(e);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; load = 1'b0;
      load_day = '0; load_month = '0; load_year = '0;

      step("reset", 0, 1, 1, 31, 12, 99, 1, 1, SY, 0, 0, 0);
      step("idle_after_reset", 1, 0, 0, 0, 0, 0, 1, 1, SY, 0, 0, 0);

      for (int k = 1; k <= 30; k++)
         step("jan_tick", 1, 1, 0, 0, 0, 0, k + 1, 1, SY, 0, 0, 0);
      step("jan_31st_tick", 1, 1, 0, 0, 0, 0, 1, 2, SY, 1, 0, 0);
      step("feb_idle", 1, 0, 0, 0, 0, 0, 1, 2, SY, 0, 0, 0);

      step("load_31_12_99", 1, 0, 1, 31, 12, 99, 31, 12, 99, 0, 0, 0);
      step("century_wrap", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0);
      step("after_wrap_idle", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

      step("load_28_2_24", 1, 0, 1, 28, 2, 24, 28, 2, 24, 0, 0, 0);
`ifdef DATE_COUNTER_LEAP_YEAR_EN
      step("feb28_tick_leap", 1, 1, 0, 0, 0, 0, 29, 2, 24, 0, 0, 0);
      step("feb29_tick_leap", 1, 1, 0, 0, 0, 0, 1, 3, 24, 1, 0, 0);
      step("load_29_2_23_bad", 1, 0, 1, 29, 2, 23, 1, 3, 24, 0, 0, 1);
`else
      step("feb28_tick", 1, 1, 0, 0, 0, 0, 1, 3, 24, 1, 0, 0);
      step("load_29_2_24_bad", 1, 0, 1, 29, 2, 24, 1, 3, 24, 0, 0, 1);
`endif

      step("load_31_4_10_bad", 1, 0, 1, 31, 4, 10, 1, 3, 24, 0, 0, 1);
      step("load_err_clears", 1, 0, 0, 0, 0, 0, 1, 3, 24, 0, 0, 0);

      step("load_with_tick", 1, 1, 1, 15, 6, 5, 15, 6, 5, 0, 0, 0);
      step("bad_load_with_tick", 1, 1, 1, 0, 6, 5, 15, 6, 5, 0, 0, 1);
      step("load_month13_bad", 1, 0, 1, 15, 13, 5, 15, 6, 5, 0, 0, 1);
      step("load_month0_bad", 1, 0, 1, 15, 0, 5, 15, 6, 5, 0, 0, 1);
      step("load_year100_bad", 1, 0, 1, 15, 6, 100, 15, 6, 5, 0, 0, 1);
      step("load_30_6_5", 1, 0, 1, 30, 6, 5, 30, 6, 5, 0, 0, 0);
      step("jun30_tick", 1, 1, 0, 0, 0, 0, 1, 7, 5, 1, 0, 0);
      step("load_31_7_5", 1, 0, 1, 31, 7, 5, 31, 7, 5, 0, 0, 0);
      step("jul31_tick", 1, 1, 0, 0, 0, 0, 1, 8, 5, 1, 0, 0);
      step("load_30_11_98", 1, 0, 1, 30, 11, 98, 30, 11, 98, 0, 0, 0);
      step("nov30_tick", 1, 1, 0, 0, 0, 0, 1, 12, 98, 1, 0, 0);
      step("load_31_12_98", 1, 0, 1, 31, 12, 98, 31, 12, 98, 0, 0, 0);
      step("year_wrap_98", 1, 1, 0, 0, 0, 0, 1, 1, 99, 1, 1, 0);

      step("held_tick_1", 1, 1, 0, 0, 0, 0, 2, 1, 99, 0, 0, 0);
      step("held_tick_2", 1, 1, 0, 0, 0, 0, 3, 1, 99, 0, 0, 0);
      step("reset_mid_tick", 0, 1, 1, 20, 5, 5, 1, 1, SY, 0, 0, 0);
      step("resume_tick", 1, 1, 0, 0, 0, 0, 2, 1, SY, 0, 0, 0);

      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
